// File: rtl/branch_target_unit_if.sv
//------------------------------------------------------------------------------
// Module  : branch_target_unit_if
// Purpose : Bundles the decode-side request (valid/op/pc/offset/condition) and
//           the fetch-side redirect response of branch_target_unit.
// Ports   : master - drives valid_in, pc_in, const_in, op_in, cond_in and
//                    observes taken, target, flush, ras_empty, ras_full, ras_err
//           slave  - the branch_target_unit side (mirror of master)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface branch_target_unit_if #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 6
);
  logic             valid_in;
  logic [PC_W-1:0]  pc_in;
  logic [OFF_W:0]   const_in;
  logic [2:0]       op_in;
  logic             cond_in;
  logic             taken;
  logic [PC_W-1:0]  target;
  logic             flush;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_err;

  modport master (
    output valid_in, pc_in, const_in, op_in, cond_in,
    input  taken, target, flush, ras_empty, ras_full, ras_err
  );

  modport slave (
    input  valid_in, pc_in, const_in, op_in, cond_in,
    output taken, target, flush, ras_empty, ras_full, ras_err
  );
endinterface

`default_nettype wire

// File: rtl/branch_target_unit.sv
//------------------------------------------------------------------------------
// Module  : branch_target_unit
// Purpose : Registered branch resolution stage. Computes PC +/- sign-magnitude
//           offset, resolves BCOND/JUMP/CALL/RET, keeps a circular
//           return-address stack and squashes fetches for FLUSH_CYC cycles
//           after every taken redirect.
// Ports   : clk   - rising-edge clock
//           reset - asynchronous active-high reset
//           bus   - branch_target_unit_if.slave (request in, redirect out)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module branch_target_unit #(
  parameter int PC_W      = 10,
  parameter int OFF_W     = 6,
  parameter int RAS_DEPTH = 4,
  parameter int FLUSH_CYC = 2
) (
  input  wire logic            clk,
  input  wire logic            reset,
  branch_target_unit_if.slave  bus
);

  localparam int SP_W  = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int FC_W  = $clog2(FLUSH_CYC + 1);

  localparam logic [SP_W-1:0]  c_SP_LAST  = SP_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [FC_W-1:0]  c_FC_LOAD  = FC_W'(FLUSH_CYC - 1);

  localparam logic [2:0] c_OP_BCOND = 3'b001;
  localparam logic [2:0] c_OP_JUMP  = 3'b010;
  localparam logic [2:0] c_OP_CALL  = 3'b011;
  localparam logic [2:0] c_OP_RET   = 3'b100;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t           r_state;
  logic [FC_W-1:0]  r_fcnt;
  logic             r_taken;
  logic [PC_W-1:0]  r_target;
  logic             r_flush;
  logic             r_ras_err;
  logic [CNT_W-1:0] r_cnt;
  logic [SP_W-1:0]  r_sp;      // next write slot; top of stack is r_sp-1
  logic [PC_W-1:0]  r_ras [RAS_DEPTH];

  logic [PC_W-1:0]  w_off;
  logic [PC_W-1:0]  w_sum;
  logic [PC_W-1:0]  w_pc_inc;
  logic [SP_W-1:0]  w_sp_next;
  logic [SP_W-1:0]  w_sp_prev;
  logic [PC_W-1:0]  w_top;
  logic             w_empty;
  logic             w_eval;
  logic             w_push;
  logic             w_pop;
  logic             w_ret_err;
  logic             w_take;
  logic [PC_W-1:0]  w_tgt_next;

  // Magnitude/sign form: a negative zero simply subtracts 0.
  assign w_off    = PC_W'(bus.const_in[OFF_W-1:0]);
  assign w_sum    = bus.const_in[OFF_W] ? (bus.pc_in - w_off) : (bus.pc_in + w_off);
  assign w_pc_inc = bus.pc_in + PC_W'(1);

  // Explicit wrap so non-power-of-two depths stay circular.
  assign w_sp_next = (r_sp == c_SP_LAST) ? '0 : (r_sp + 1'b1);
  assign w_sp_prev = (r_sp == '0) ? c_SP_LAST : (r_sp - 1'b1);
  assign w_top     = r_ras[w_sp_prev];
  assign w_empty   = (r_cnt == '0);

  // Requests are only honoured while not squashing.
  assign w_eval    = (r_state == S_IDLE) && bus.valid_in;
  assign w_push    = w_eval && (bus.op_in == c_OP_CALL);
  assign w_pop     = w_eval && (bus.op_in == c_OP_RET) && !w_empty;
  assign w_ret_err = w_eval && (bus.op_in == c_OP_RET) && w_empty;
  assign w_take    = w_eval && (((bus.op_in == c_OP_BCOND) && bus.cond_in) ||
                                (bus.op_in == c_OP_JUMP) ||
                                (bus.op_in == c_OP_CALL) ||
                                w_pop);

  always_comb begin
    w_tgt_next = r_target;
    if (w_eval) begin
      case (bus.op_in)
        c_OP_BCOND, c_OP_JUMP, c_OP_CALL: w_tgt_next = w_sum;
        c_OP_RET:                         w_tgt_next = w_empty ? w_pc_inc : w_top;
        default:                          w_tgt_next = r_target;
      endcase
    end
  end

  // Stack storage needs no reset: validity is tracked by r_cnt.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ras[r_sp] <= w_pc_inc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_fcnt    <= '0;
      r_taken   <= 1'b0;
      r_target  <= '0;
      r_flush   <= 1'b0;
      r_ras_err <= 1'b0;
      r_cnt     <= '0;
      r_sp      <= '0;
    end else begin
      r_taken   <= w_take;
      r_ras_err <= w_ret_err;
      r_target  <= w_tgt_next;

      // A push on a full stack overwrites the oldest slot; count saturates.
      if (w_push) begin
        r_sp <= w_sp_next;
        if (r_cnt != c_CNT_FULL) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else if (w_pop) begin
        r_sp  <= w_sp_prev;
        r_cnt <= r_cnt - 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_state <= S_FLUSH;
            r_fcnt  <= c_FC_LOAD;
            r_flush <= 1'b1;
          end
        end
        S_FLUSH: begin
          if (r_fcnt == '0) begin
            r_state <= S_IDLE;
            r_flush <= 1'b0;
          end else begin
            r_fcnt <= r_fcnt - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  assign bus.taken     = r_taken;
  assign bus.target    = r_target;
  assign bus.flush     = r_flush;
  assign bus.ras_err   = r_ras_err;
  assign bus.ras_empty = w_empty;
  assign bus.ras_full  = (r_cnt == c_CNT_FULL);

endmodule

`default_nettype wire

// File: tb/tb_branch_target_unit.sv
//------------------------------------------------------------------------------
// Module  : tb_branch_target_unit
// Purpose : Self-checking bench for branch_target_unit: directed scenarios
//           followed by random traffic compared against a behavioural model
//           (queue-based stack, countdown of squashed cycles).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_branch_target_unit;

  localparam int PC_W      = 10;
  localparam int OFF_W     = 6;
  localparam int RAS_DEPTH = 4;
  localparam int FLUSH_CYC = 2;
  localparam int c_MASK    = (1 << PC_W) - 1;

  localparam logic [2:0] c_NOP   = 3'd0;
  localparam logic [2:0] c_BCOND = 3'd1;
  localparam logic [2:0] c_JUMP  = 3'd2;
  localparam logic [2:0] c_CALL  = 3'd3;
  localparam logic [2:0] c_RET   = 3'd4;

  logic clk;
  logic reset;

  branch_target_unit_if #(.PC_W(PC_W), .OFF_W(OFF_W)) bus ();

  branch_target_unit #(
    .PC_W(PC_W), .OFF_W(OFF_W), .RAS_DEPTH(RAS_DEPTH), .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_stack[$];
  int m_busy;
  int m_taken;
  int m_target;
  int m_flush;
  int m_err;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_stack.delete();
    m_busy   = 0;
    m_taken  = 0;
    m_target = 0;
    m_flush  = 0;
    m_err    = 0;
  endtask

  // Applied at each rising edge with the inputs presented to the DUT.
  task automatic model_edge(input bit v, input logic [2:0] op, input int pc,
                            input logic [OFF_W:0] cst, input bit cond);
    int mag;
    int sum;
    m_err   = 0;
    m_taken = 0;
    if (m_busy > 0) begin
      m_busy--;
      m_flush = (m_busy > 0);
      return;
    end
    m_flush = 0;
    if (!v) return;
    mag = int'(cst[OFF_W-1:0]);
    sum = (cst[OFF_W] ? pc - mag : pc + mag) & c_MASK;
    case (op)
      c_BCOND: begin m_target = sum; m_taken = cond; end
      c_JUMP:  begin m_target = sum; m_taken = 1; end
      c_CALL: begin
        m_target = sum;
        m_taken  = 1;
        m_stack.push_back((pc + 1) & c_MASK);
        if (m_stack.size() > RAS_DEPTH) void'(m_stack.pop_front());
      end
      c_RET: begin
        if (m_stack.size() > 0) begin
          m_target = m_stack.pop_back();
          m_taken  = 1;
        end else begin
          m_target = (pc + 1) & c_MASK;
          m_err    = 1;
        end
      end
      default: ;
    endcase
    if (m_taken) begin
      m_busy  = FLUSH_CYC;
      m_flush = 1;
    end
  endtask

  task automatic check_all(input string ctx);
    check_val({ctx, ".taken"},  32'(bus.taken),     32'(m_taken));
    check_val({ctx, ".target"}, 32'(bus.target),    32'(m_target));
    check_val({ctx, ".flush"},  32'(bus.flush),     32'(m_flush));
    check_val({ctx, ".empty"},  32'(bus.ras_empty), 32'(m_stack.size() == 0));
    check_val({ctx, ".full"},   32'(bus.ras_full),  32'(m_stack.size() == RAS_DEPTH));
    check_val({ctx, ".err"},    32'(bus.ras_err),   32'(m_err));
  endtask

  // One clock: drive on the falling edge, update model at the rising edge,
  // compare 1 time unit later.
  task automatic cycle(input string ctx, input bit v, input logic [2:0] op,
                       input int pc, input logic [OFF_W:0] cst, input bit cond);
    @(negedge clk);
    bus.valid_in = v;
    bus.op_in    = op;
    bus.pc_in    = PC_W'(pc);
    bus.const_in = cst;
    bus.cond_in  = cond;
    @(posedge clk);
    model_edge(v, op, pc, cst, cond);
    #1;
    check_all(ctx);
  endtask

  task automatic idle(input string ctx, input int n);
    for (int i = 0; i < n; i++) cycle(ctx, 1'b0, c_NOP, 0, '0, 1'b0);
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.op_in    = c_NOP;
    bus.pc_in    = '0;
    bus.const_in = '0;
    bus.cond_in  = 1'b0;
    reset        = 1'b1;
    model_reset();
    #12;
    check_val("rst.taken",  32'(bus.taken),     32'd0);
    check_val("rst.target", 32'(bus.target),    32'd0);
    check_val("rst.flush",  32'(bus.flush),     32'd0);
    check_val("rst.empty",  32'(bus.ras_empty), 32'd1);
    check_val("rst.full",   32'(bus.ras_full),  32'd0);
    check_val("rst.err",    32'(bus.ras_err),   32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Negative offset JUMP, flush lasts FLUSH_CYC cycles
    cycle("jmp", 1'b1, c_JUMP, 100, {1'b1, 6'd5}, 1'b0);
    check_val("jmp.target95", 32'(bus.target), 32'd95);
    check_val("jmp.taken1",   32'(bus.taken),  32'd1);
    check_val("jmp.flush_c1", 32'(bus.flush),  32'd1);
    idle("jmp_fl", 1);
    check_val("jmp.flush_c2", 32'(bus.flush),  32'd1);
    check_val("jmp.taken_pulse", 32'(bus.taken), 32'd0);
    idle("jmp_fl", 1);
    check_val("jmp.flush_off", 32'(bus.flush), 32'd0);

    // Not-taken branch still updates target
    cycle("bnt", 1'b1, c_BCOND, 100, {1'b0, 6'd10}, 1'b0);
    check_val("bnt.target110", 32'(bus.target), 32'd110);
    check_val("bnt.taken0",    32'(bus.taken),  32'd0);
    check_val("bnt.flush0",    32'(bus.flush),  32'd0);

    // Wrap in both directions, and -0
    cycle("wrap_up", 1'b1, c_JUMP, 1020, {1'b0, 6'd10}, 1'b0);
    check_val("wrap_up.target6", 32'(bus.target), 32'd6);
    idle("wrap_fl", FLUSH_CYC);
    cycle("wrap_dn", 1'b1, c_JUMP, 3, {1'b1, 6'd5}, 1'b0);
    check_val("wrap_dn.target1022", 32'(bus.target), 32'd1022);
    idle("wrap_fl", FLUSH_CYC);
    cycle("negzero", 1'b1, c_BCOND, 77, {1'b1, 6'd0}, 1'b1);
    check_val("negzero.target77", 32'(bus.target), 32'd77);
    idle("nz_fl", FLUSH_CYC);

    // Overfill the stack, then drain it past empty
    for (int i = 1; i <= 5; i++) begin
      cycle("call", 1'b1, c_CALL, 10 * i, {1'b0, 6'd3}, 1'b0);
      idle("call_fl", FLUSH_CYC);
    end
    check_val("call.full", 32'(bus.ras_full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cycle("ret", 1'b1, c_RET, 200, '0, 1'b0);
      check_val("ret.target", 32'(bus.target), 32'(51 - 10 * i));
      idle("ret_fl", FLUSH_CYC);
    end
    cycle("ret_empty", 1'b1, c_RET, 300, '0, 1'b0);
    check_val("ret_empty.err",    32'(bus.ras_err), 32'd1);
    check_val("ret_empty.taken",  32'(bus.taken),   32'd0);
    check_val("ret_empty.target", 32'(bus.target),  32'd301);
    idle("after_err", 1);
    check_val("ret_empty.err_pulse", 32'(bus.ras_err), 32'd0);

    // Request during flush is ignored
    cycle("jmp2", 1'b1, c_JUMP, 500, {1'b0, 6'd1}, 1'b0);
    cycle("call_ign", 1'b1, c_CALL, 600, {1'b0, 6'd2}, 1'b0);
    check_val("call_ign.empty",  32'(bus.ras_empty), 32'd1);
    check_val("call_ign.target", 32'(bus.target),    32'd501);
    idle("ign_fl", FLUSH_CYC);

    // Asynchronous reset in the middle of a flush
    cycle("c1", 1'b1, c_CALL, 700, '0, 1'b0);
    idle("c1_fl", FLUSH_CYC);
    cycle("c2", 1'b1, c_CALL, 710, '0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_val("arst.flush", 32'(bus.flush),     32'd0);
    check_val("arst.taken", 32'(bus.taken),     32'd0);
    check_val("arst.empty", 32'(bus.ras_empty), 32'd1);
    @(negedge clk);
    bus.valid_in = 1'b0;
    reset        = 1'b0;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle("rnd", ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
            int'($urandom_range(0, c_MASK)), (OFF_W + 1)'($urandom),
            1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
